// File: rtl/read_data_router_pkg.sv
// Shared read-data interconnect definitions.
// Holds the AXI RRESP encodings, the read-data router FSM states, and the
// ID width derivation that is common with the read-data arbiter.
package read_data_router_pkg;

   typedef enum logic [1:0] {
      RRESP_OKAY   = 2'b00,
      RRESP_EXOKAY = 2'b01,
      RRESP_SLVERR = 2'b10,
      RRESP_DECERR = 2'b11
   } rresp_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } rd_state_e;

   // Index width for n items; kept at least 1 bit so degenerate counts
   // still produce legal vector widths. MW = idx_width(M),
   // TW = idx_width(NUM_OUTSTANDING_TRANS), IW = MW + TW.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/r_beat_buffer.sv
// One-entry output register for R beats.
// Ports: clk/clr (async active-low reset), load_i (capture din_i),
// drain_i (consumer took the entry), din_i payload, valid_o/dout_o entry.
// A load in the same cycle as a drain replaces the entry without a bubble.
module r_beat_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic [W-1:0] din_i,
   output logic         valid_o,
   output logic [W-1:0] dout_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = din_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign dout_o  = data_q;

endmodule

// File: rtl/read_data_router.sv
// Read-data router: forwards R beats from the arbiter-granted slave to the
// master selected by the arbiter, through a one-entry output register.
// Ports: slave R channel (s_*), arbiter handshake (R_grant_f, R_sel_f in;
// R_request_f, R_id_f, R_last_f out), master R channel (m_*), and a sticky
// proto_err flag raised on grant changes or ID/selection disagreement
// during a burst. clr is an asynchronous active-low reset.
module read_data_router
   import read_data_router_pkg::*;
#(
   parameter  int unsigned M                     = 2,
   parameter  int unsigned S                     = 2,
   parameter  int unsigned NUM_OUTSTANDING_TRANS = 2,
   parameter  int unsigned DATA_WIDTH            = 32,
   localparam int unsigned TW                    = idx_width(NUM_OUTSTANDING_TRANS),
   localparam int unsigned MW                    = idx_width(M),
   localparam int unsigned IW                    = MW + TW
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [S-1:0]            s_rvalid,
   output logic [S-1:0]            s_rready,
   input  logic [S*DATA_WIDTH-1:0] s_rdata,
   input  logic [S*2-1:0]          s_rresp,
   input  logic [S-1:0]            s_rlast,
   input  logic [S*IW-1:0]         s_rid,
   input  logic [S-1:0]            R_grant_f,
   input  logic [S*MW-1:0]         R_sel_f,
   output logic [S-1:0]            R_request_f,
   output logic [S*IW-1:0]         R_id_f,
   output logic [S-1:0]            R_last_f,
   output logic [M-1:0]            m_rvalid,
   input  logic [M-1:0]            m_rready,
   output logic [M*DATA_WIDTH-1:0] m_rdata,
   output logic [M*2-1:0]          m_rresp,
   output logic [M-1:0]            m_rlast,
   output logic [M*TW-1:0]         m_rid,
   output logic                    proto_err
);

   localparam int unsigned SW = idx_width(S);
   localparam int unsigned PW = MW + DATA_WIDTH + 2 + 1 + TW;

   // Granted-slave view
   logic                  gnt_any;
   logic [SW-1:0]         gnt_idx;
   logic                  g_valid, g_last;
   logic [DATA_WIDTH-1:0] g_data;
   logic [1:0]            g_resp;
   logic [IW-1:0]         g_rid;
   logic [MW-1:0]         g_sel;

   // Buffered beat
   logic                  buf_valid;
   logic [PW-1:0]         buf_payload;
   logic [MW-1:0]         buf_dest;
   logic [DATA_WIDTH-1:0] buf_data;
   logic [1:0]            buf_resp;
   logic                  buf_last;
   logic [TW-1:0]         buf_tid;

   logic dest_ready, room, accept, drain;

   rd_state_e     state_q;
   logic [SW-1:0] burst_slv_q;
   logic          proto_err_q;

   assign R_request_f = s_rvalid;
   assign R_id_f      = s_rid;

   // Lowest-index grant wins; later (higher) grants are ignored.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      g_resp  = RRESP_OKAY;
      g_rid   = '0;
      g_sel   = '0;
      for (int unsigned s = 0; s < S; s++) begin
         if (R_grant_f[s] && !gnt_any) begin
            gnt_any = 1'b1;
            gnt_idx = SW'(s);
            g_valid = s_rvalid[s];
            g_last  = s_rlast[s];
            g_data  = s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
            g_resp  = s_rresp[s*2 +: 2];
            g_rid   = s_rid[s*IW +: IW];
            g_sel   = R_sel_f[s*MW +: MW];
         end
      end
   end

   always_comb begin
      dest_ready = 1'b0;
      for (int unsigned d = 0; d < M; d++) begin
         if (buf_dest == MW'(d)) dest_ready = m_rready[d];
      end
   end

   assign room   = !buf_valid || dest_ready;
   assign accept = gnt_any && g_valid && room;
   assign drain  = buf_valid && dest_ready;

   always_comb begin
      s_rready = '0;
      R_last_f = '0;
      for (int unsigned s = 0; s < S; s++) begin
         if (gnt_any && gnt_idx == SW'(s)) begin
            s_rready[s] = room;
            R_last_f[s] = accept && g_last;
         end
      end
   end

   r_beat_buffer #(.W(PW)) u_buf (
      .clk    (clk),
      .clr    (clr),
      .load_i (accept),
      .drain_i(drain),
      .din_i  ({g_sel, g_data, g_resp, g_last, g_rid[TW-1:0]}),
      .valid_o(buf_valid),
      .dout_o (buf_payload)
   );

   assign {buf_dest, buf_data, buf_resp, buf_last, buf_tid} = buf_payload;

   // Payload fans out to every master; only the valid is steered.
   always_comb begin
      m_rvalid = '0;
      for (int unsigned d = 0; d < M; d++) begin
         m_rvalid[d] = buf_valid && (buf_dest == MW'(d));
      end
   end

   assign m_rdata   = {M{buf_data}};
   assign m_rresp   = {M{buf_resp}};
   assign m_rlast   = {M{buf_last}};
   assign m_rid     = {M{buf_tid}};
   assign proto_err = proto_err_q;

   // Burst tracker: remembers the slave that opened a multi-beat burst so a
   // grant move or ID/selection mismatch before rlast can be flagged.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= ST_IDLE;
         burst_slv_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         if (state_q == ST_XFER &&
             ((gnt_any && gnt_idx != burst_slv_q) ||
              (accept && g_rid[IW-1:TW] != g_sel))) begin
            proto_err_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept && !g_last) begin
                  state_q     <= ST_XFER;
                  burst_slv_q <= gnt_idx;
               end
            end
            ST_XFER: begin
               if (accept && g_last) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/read_data_router.md
READ_DATA_ROUTER -- requirements
Module: read_data_router

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- M, 2, master count.
- S, 2, slave count.
- NUM_OUTSTANDING_TRANS, 2, IDs per master.
- DATA_WIDTH, 32, R beat width.
- Derived widths: TW=$clog2(NUM_OUTSTANDING_TRANS), MW=$clog2(M), IW=MW+TW.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Flattened buses are packed index-major, LSB = index 0.
- clk, input, 1, clock.
- clr, input, 1, asynchronous active-low reset.
- s_rvalid, input, S, slave R valid.
- s_rready, output, S, slave R ready.
- s_rdata, input, S*DATA_WIDTH, slave R data.
- s_rresp, input, S*2, slave R response.
- s_rlast, input, S, slave R last.
- s_rid, input, S*IW, slave R ID: {master index, transaction ID}.
- R_grant_f, input, S, read-data arbiter grant.
- R_sel_f, input, S*MW, arbiter-selected master per slave.
- R_request_f, output, S, request to arbiter.
- R_id_f, output, S*IW, ID to arbiter.
- R_last_f, output, S, burst-end pulse to arbiter.
- m_rvalid, output, M, master R valid.
- m_rready, input, M, master R ready.
- m_rdata, output, M*DATA_WIDTH, master R data.
- m_rresp, output, M*2, master R response.
- m_rlast, output, M, master R last.
- m_rid, output, M*TW, transaction ID with the master index stripped.
- proto_err, output, 1, sticky protocol error.

Function
REQ-003 R_request_f[s] SHALL equal s_rvalid[s], and R_id_f slice s SHALL equal s_rid slice s (combinational).
REQ-004 Granted slave g SHALL be the lowest index with R_grant_f set; with no grant set, all s_rready SHALL be 0.
REQ-005 Data path: one-entry output register holding {valid, dest, data, resp, last, tid}.
- dest is taken from R_sel_f slice g.
- tid is s_rid[TW-1:0] of g.
REQ-006 s_rready[g] SHALL be R_grant_f[g] && (!buf_valid || m_rready[buf_dest]); s_rready of every other slave SHALL be 0.
REQ-007 Accept (s_rvalid[g] && s_rready[g]) SHALL load the register on the next edge.
- Simultaneous drain and accept SHALL replace the entry with no bubble, giving full throughput.
- Latency, slave handshake to m_rvalid: 1 cycle.
REQ-008 m_rvalid[d] SHALL be buf_valid && d==buf_dest; for all other masters it SHALL be 0.
- Payload is driven to every master; only the valid is gated.
REQ-009 Drain (m_rvalid[buf_dest] && m_rready[buf_dest]) with no accept in the same cycle SHALL clear buf_valid.
REQ-010 R_last_f[g] SHALL pulse 1 for exactly the cycle in which a beat with s_rlast=1 is accepted from g, and SHALL be 0 otherwise.
REQ-011 FSM states: IDLE, XFER.
- IDLE -> XFER on the first accepted beat without rlast.
- A single-beat burst (rlast on first beat) SHALL stay in IDLE.
- XFER -> IDLE on an accepted beat with rlast.
REQ-012 In XFER, proto_err SHALL set on either event:
- the grant moves to a different slave before rlast;
- the accepted s_rid master field differs from R_sel_f.
REQ-013 proto_err SHALL be sticky until reset; data forwarding SHALL continue unaffected.
REQ-014 Grant deassertion while buf_valid=1 SHALL NOT drop the buffered beat; it drains normally to its master.
REQ-015 m_rvalid SHALL NOT retract and its payload SHALL NOT change until drained; this is AXI stability.

Reset
REQ-016 clr low SHALL asynchronously clear buf_valid, the FSM (to IDLE) and proto_err; all registered outputs read 0.
REQ-017 Reset mid-burst SHALL discard the buffered beat; no m_rvalid after release until a new accept.

Structure
REQ-018 The shared interconnect package SHALL hold the AXI RRESP encodings, the FSM state constants, and the ID width derivation (MW/TW/IW), which is common with the read-data arbiter.
REQ-019 The output register SHALL be one sub-module, r_beat_buffer, parameterised by payload width.

Verification
REQ-020 Directed scenarios (M=S=2, DATA_WIDTH=32):
- Grant slave 1, sel=0, 4-beat burst 0xA0..0xA3, m_rready=1 -> master 0 sees the 4 beats one cycle later, back-to-back; R_last_f[1] pulses once, on beat 4 accept; masters 1 m_rvalid=0 throughout.
- Same burst, m_rready[0] low for 3 cycles mid-burst -> s_rready[1]=0 while buffer full; no beat lost or duplicated; order preserved.
- Single-beat burst, rlast=1, grant slave 0, s_rid={1,1} -> m_rvalid[1] one cycle, m_rid=1; FSM stays IDLE; R_last_f[0] pulses once.
- Grant switches from slave 0 to slave 1 after beat 2 of a 4-beat burst -> proto_err=1 and stays 1; beat 2 still delivered.
- clr asserted with buffer full -> m_rvalid=0 immediately; proto_err=0; the next burst after release is routed correctly.
- No grant, s_rvalid=2'b11 -> R_request_f=2'b11, s_rready=0, all m_rvalid=0.
